// File: rtl/register_bank16_scan.sv
// 16 x 8-bit register bank feeding a 16:1 byte mux, with a valid/ready scan
// sequencer that walks the mux select through indices 0..SCAN_LAST.
module register_bank16_scan #(
  parameter logic [7:0] RESET_VAL = 8'h00,
  parameter int         SCAN_LAST = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [3:0] rd_sel,
  output logic [7:0] r0,
  output logic [7:0] r1,
  output logic [7:0] r2,
  output logic [7:0] r3,
  output logic [7:0] r4,
  output logic [7:0] r5,
  output logic [7:0] r6,
  output logic [7:0] r7,
  output logic [7:0] r8,
  output logic [7:0] r9,
  output logic [7:0] r10,
  output logic [7:0] r11,
  output logic [7:0] r12,
  output logic [7:0] r13,
  output logic [7:0] r14,
  output logic [7:0] r15,
  output logic [3:0] sel,
  input  logic       dump_start,
  output logic       dump_valid,
  input  logic       dump_ready,
  output logic       dump_last,
  output logic       dump_busy,
  output logic       dump_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(SCAN_LAST);

  logic [7:0] regs_r [16];
  state_t     state_r, state_s;
  logic [3:0] idx_r, idx_s;
  logic       valid_r, busy_r, done_r;
  logic       valid_s, busy_s, done_s;

  // Register file: clr outranks a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs_r[i] <= RESET_VAL;
    end else if (clr) begin
      for (int i = 0; i < 16; i++) regs_r[i] <= RESET_VAL;
    end else if (wr_en) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

  assign r0  = regs_r[0];
  assign r1  = regs_r[1];
  assign r2  = regs_r[2];
  assign r3  = regs_r[3];
  assign r4  = regs_r[4];
  assign r5  = regs_r[5];
  assign r6  = regs_r[6];
  assign r7  = regs_r[7];
  assign r8  = regs_r[8];
  assign r9  = regs_r[9];
  assign r10 = regs_r[10];
  assign r11 = regs_r[11];
  assign r12 = regs_r[12];
  assign r13 = regs_r[13];
  assign r14 = regs_r[14];
  assign r15 = regs_r[15];

  // Sequencer state, scan index and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= 4'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Next-state and next-index logic; valid is always high in SCAN, so ready alone accepts.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (dump_start) begin
          state_s = SCAN;
          idx_s   = 4'd0;
        end else begin
          state_s = IDLE;
          idx_s   = 4'd0;
        end
      end
      SCAN: begin
        if (dump_ready) begin
          if (idx_r == LAST_IDX) begin
            state_s = DONE;
          end else begin
            idx_s = idx_r + 4'd1;
          end
        end else begin
          state_s = SCAN;
        end
      end
      DONE: begin
        state_s = IDLE;
        idx_s   = 4'd0;
      end
      default: begin
        state_s = IDLE;
        idx_s   = 4'd0;
      end
    endcase
  end

  // Output decode: handshake flags from the next state, select and last from the current one.
  always_comb begin
    valid_s   = (state_s == SCAN);
    busy_s    = (state_s != IDLE);
    done_s    = (state_s == DONE);
    dump_last = (state_r == SCAN) && (idx_r == LAST_IDX);
    case (state_r)
      IDLE:    sel = rd_sel;
      SCAN:    sel = idx_r;
      DONE:    sel = LAST_IDX;
      default: sel = rd_sel;
    endcase
  end

  assign dump_valid = valid_r;
  assign dump_busy  = busy_r;
  assign dump_done  = done_r;

endmodule

// File: tb/tb_register_bank16_scan.sv
// Directed bench for register_bank16_scan: a full-size bank and a SCAN_LAST = 3 bank.
module tb_register_bank16_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = 4'd0;
  logic [7:0] wr_data = 8'h00;
  logic [3:0] rd_sel = 4'd0;
  logic       dump_start = 1'b0;
  logic       dump_ready = 1'b0;
  logic [7:0] rv [16];
  logic [3:0] sel;
  logic       dump_valid, dump_last, dump_busy, dump_done;

  logic       start2 = 1'b0;
  logic       ready2 = 1'b0;
  logic [7:0] rv2 [16];
  logic [3:0] sel2;
  logic       valid2, last2, busy2, done2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  register_bank16_scan #(.RESET_VAL(8'h00), .SCAN_LAST(15)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_sel(rd_sel),
    .r0(rv[0]), .r1(rv[1]), .r2(rv[2]), .r3(rv[3]), .r4(rv[4]), .r5(rv[5]),
    .r6(rv[6]), .r7(rv[7]), .r8(rv[8]), .r9(rv[9]), .r10(rv[10]), .r11(rv[11]),
    .r12(rv[12]), .r13(rv[13]), .r14(rv[14]), .r15(rv[15]),
    .sel(sel), .dump_start(dump_start), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_last(dump_last), .dump_busy(dump_busy),
    .dump_done(dump_done)
  );

  register_bank16_scan #(.RESET_VAL(8'h00), .SCAN_LAST(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .wr_en(1'b0), .wr_addr(4'd0),
    .wr_data(8'h00), .rd_sel(4'd12),
    .r0(rv2[0]), .r1(rv2[1]), .r2(rv2[2]), .r3(rv2[3]), .r4(rv2[4]), .r5(rv2[5]),
    .r6(rv2[6]), .r7(rv2[7]), .r8(rv2[8]), .r9(rv2[9]), .r10(rv2[10]), .r11(rv2[11]),
    .r12(rv2[12]), .r13(rv2[13]), .r14(rv2[14]), .r15(rv2[15]),
    .sel(sel2), .dump_start(start2), .dump_valid(valid2),
    .dump_ready(ready2), .dump_last(last2), .dump_busy(busy2),
    .dump_done(done2)
  );

  task automatic test_reset;
    rst_n = 1'b0;
    rd_sel = 4'd9;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (rv[i] !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_r%0d got %h want 00", i, rv[i]);
      end
    end
    vectors++;
    if ({dump_valid, dump_last, dump_busy, dump_done} !== 4'b0000 || sel !== 4'd9) begin
      miscompares++;
      $display("FAIL reset_ctl got v%b l%b b%b d%b sel%0d want 0000 sel9",
               dump_valid, dump_last, dump_busy, dump_done, sel);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      wr_addr = 4'(i);
      wr_data = 8'h10 + 8'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    rd_sel = 4'd5;
    #1;
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (rv[i] !== 8'h10 + 8'(i)) begin
        miscompares++;
        $display("FAIL load_r%0d got %h want %h", i, rv[i], 8'h10 + 8'(i));
      end
    end
    vectors++;
    if (sel !== 4'd5 || rv[5] !== 8'h15) begin
      miscompares++;
      $display("FAIL rd_sel got sel%0d r5=%h want sel5 r5=15", sel, rv[5]);
    end
  endtask

  task automatic test_full_dump;
    int done_cnt = 0;
    @(negedge clk);
    dump_start = 1'b1;
    dump_ready = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (sel !== 4'(k) || dump_valid !== 1'b1 || dump_busy !== 1'b1 ||
          dump_last !== (k == 15) || dump_done !== 1'b0) begin
        miscompares++;
        $display("FAIL dump_step%0d got sel%0d v%b b%b l%b d%b", k, sel,
                 dump_valid, dump_busy, dump_last, dump_done);
      end
      @(negedge clk);
    end
    if (dump_done === 1'b1) done_cnt++;
    vectors++;
    if (dump_done !== 1'b1 || dump_valid !== 1'b0 || dump_busy !== 1'b1 || sel !== 4'd15) begin
      miscompares++;
      $display("FAIL dump_doneslot got d%b v%b b%b sel%0d want d1 v0 b1 sel15",
               dump_done, dump_valid, dump_busy, sel);
    end
    @(negedge clk);
    if (dump_done === 1'b1) done_cnt++;
    @(negedge clk);
    if (dump_done === 1'b1) done_cnt++;
    vectors++;
    if (done_cnt !== 1 || dump_busy !== 1'b0 || sel !== rd_sel) begin
      miscompares++;
      $display("FAIL dump_idle got done_cnt%0d b%b sel%0d want 1 0 %0d",
               done_cnt, dump_busy, sel, rd_sel);
    end
  endtask

  task automatic test_stall;
    int scan_cycles = 0;
    int stall_cnt = 0;
    int exp_idx = 0;
    int budget = 0;
    dump_start = 1'b1;
    dump_ready = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    while (dump_done !== 1'b1 && budget < 60) begin
      budget++;
      if (dump_valid === 1'b1) begin
        scan_cycles++;
        if (sel === 4'd7 && stall_cnt < 3) begin
          if (stall_cnt > 0) begin
            vectors++;
            if (sel !== 4'd7 || dump_valid !== 1'b1) begin
              miscompares++;
              $display("FAIL stall_hold got sel%0d v%b want sel7 v1", sel, dump_valid);
            end
          end
          dump_ready = 1'b0;
          stall_cnt++;
        end else begin
          dump_ready = 1'b1;
          vectors++;
          if (sel !== 4'(exp_idx)) begin
            miscompares++;
            $display("FAIL stall_order got sel%0d want %0d", sel, exp_idx);
          end
          exp_idx++;
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (budget >= 60 || scan_cycles !== 19 || exp_idx !== 16) begin
      miscompares++;
      $display("FAIL stall_len got cycles%0d accepted%0d budget%0d want 19 16",
               scan_cycles, exp_idx, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_during_scan;
    int phase = 0;
    int exp_idx = 0;
    int budget = 0;
    logic [7:0] exp_data;
    dump_start = 1'b1;
    dump_ready = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    while (dump_done !== 1'b1 && budget < 60) begin
      budget++;
      wr_en = 1'b0;
      if (sel === 4'd3 && phase == 0) begin
        dump_ready = 1'b0;
        wr_en = 1'b1;
        wr_addr = 4'd3;
        wr_data = 8'hAA;
        phase = 1;
      end else begin
        if (phase == 1) begin
          vectors++;
          if (sel !== 4'd3 || rv[3] !== 8'hAA || dump_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_stalled got sel%0d r3=%h v%b want sel3 aa v1", sel, rv[3], dump_valid);
          end
          wr_en = 1'b1;
          wr_addr = 4'd1;
          wr_data = 8'h55;
          phase = 2;
        end
        dump_ready = 1'b1;
        exp_data = (exp_idx == 3) ? 8'hAA : 8'h10 + 8'(exp_idx);
        vectors++;
        if (sel !== 4'(exp_idx) || rv[sel] !== exp_data) begin
          miscompares++;
          $display("FAIL wr_accept got sel%0d data%h want sel%0d data%h",
                   sel, rv[sel], exp_idx, exp_data);
        end
        exp_idx++;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    vectors++;
    if (budget >= 60 || exp_idx !== 16 || rv[1] !== 8'h55) begin
      miscompares++;
      $display("FAIL wr_summary got accepted%0d r1=%h budget%0d want 16 55", exp_idx, rv[1], budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_scan;
    int budget = 0;
    int done_seen = 0;
    dump_start = 1'b1;
    dump_ready = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    while (sel !== 4'd9 && budget < 30) begin
      budget++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (budget >= 30 || dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid got v%b b%b d%b budget%0d want 000", dump_valid, dump_busy, dump_done, budget);
    end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (rv[i] !== 8'h00) begin
        miscompares++;
        $display("FAIL rst_mid_r%0d got %h want 00", i, rv[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (dump_done === 1'b1 || dump_busy === 1'b1) done_seen++;
    end
    vectors++;
    if (done_seen !== 0) begin
      miscompares++;
      $display("FAIL rst_mid_nodone got %0d busy/done cycles want 0", done_seen);
    end
  endtask

  task automatic test_clr_priority;
    wr_en = 1'b1;
    wr_addr = 4'd2;
    wr_data = 8'h77;
    @(negedge clk);
    vectors++;
    if (rv[2] !== 8'h77) begin
      miscompares++;
      $display("FAIL clr_pre got %h want 77", rv[2]);
    end
    clr = 1'b1;
    wr_data = 8'h5A;
    @(negedge clk);
    clr = 1'b0;
    wr_en = 1'b0;
    vectors++;
    if (rv[2] !== 8'h00) begin
      miscompares++;
      $display("FAIL clr_wr got %h want 00", rv[2]);
    end
  endtask

  task automatic test_scan_last3;
    start2 = 1'b1;
    ready2 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (sel2 !== 4'(k) || valid2 !== 1'b1 || last2 !== (k == 3)) begin
        miscompares++;
        $display("FAIL s3_step%0d got sel%0d v%b l%b", k, sel2, valid2, last2);
      end
      @(negedge clk);
    end
    start2 = 1'b0;
    vectors++;
    if (done2 !== 1'b1 || valid2 !== 1'b0 || sel2 !== 4'd3) begin
      miscompares++;
      $display("FAIL s3_done got d%b v%b sel%0d want 1 0 3", done2, valid2, sel2);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (busy2 !== 1'b0 || valid2 !== 1'b0 || sel2 !== 4'd12) begin
      miscompares++;
      $display("FAIL s3_noqueue got b%b v%b sel%0d want 0 0 12", busy2, valid2, sel2);
    end
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    vectors++;
    if (sel2 !== 4'd0 || valid2 !== 1'b1 || busy2 !== 1'b1) begin
      miscompares++;
      $display("FAIL s3_restart got sel%0d v%b b%b want 0 1 1", sel2, valid2, busy2);
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load();
    test_full_dump();
    test_stall();
    test_write_during_scan();
    test_reset_mid_scan();
    test_clr_priority();
    test_scan_last3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/register_bank16_scan.md
Name: register_bank16_scan

Overview:
- 16-entry x 8-bit register bank that sits directly upstream of the 16:1 byte multiplexer.
- All 16 registers drive the mux inputs in parallel (r0..r15 -> in0..in15).
- The block also generates the 4-bit select that picks which register the mux presents.
- A built-in scan sequencer walks the select through the registers under a valid/ready handshake, so a downstream consumer can dump the bank through the mux output.

Parameters:
RESET_VAL, 8'h00, value loaded into every register on reset and on clr
SCAN_LAST, 15, highest index visited by a dump (legal range 0..15); a dump covers indices 0..SCAN_LAST

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear of all 16 registers to RESET_VAL
wr_en  input  1  write strobe
wr_addr  input  4  register index to write
wr_data  input  8  write data
rd_sel  input  4  direct select, used when no dump is active
r0..r15  output  8 each  register contents, one port per register, to mux in0..in15
sel  output  4  select driven to mux sel
dump_start  input  1  request a full scan; sampled only in IDLE
dump_valid  output  1  mux output currently holds a dump element
dump_ready  input  1  consumer accepts the current element
dump_last  output  1  high with dump_valid when sel == SCAN_LAST
dump_busy  output  1  high in SCAN and DONE
dump_done  output  1  one-cycle pulse after the final element is accepted

Behaviour:
- Reset (async assert, sync release):
  - all registers = RESET_VAL
  - state = IDLE; scan index = 0
  - dump_valid, dump_last, dump_busy, dump_done = 0
  - sel = rd_sel, combinationally
- Write:
  - on a rising edge with wr_en = 1, register[wr_addr] <= wr_data. Visible on rN the next cycle; zero read-after-write bypass.
  - clr has priority over wr_en in the same cycle.
  - Writes are permitted in every state.
- sel mux:
  - IDLE: sel = rd_sel.
  - SCAN: sel = scan index register.
  - DONE: sel = SCAN_LAST.
- State machine:
  - IDLE: dump_start = 1 -> SCAN with index = 0, dump_valid = 1 on the next cycle.
  - SCAN: dump_valid = 1 throughout.
    - valid & ready with index < SCAN_LAST -> index + 1.
    - valid & ready with index == SCAN_LAST -> DONE.
    - ready = 0 -> index and sel hold; the element is stalled indefinitely.
  - DONE: one cycle. dump_done = 1, dump_valid = 0, then -> IDLE with index reset to 0.
- dump_last is combinational: (state == SCAN) && (index == SCAN_LAST).
- dump_start while in SCAN or DONE is ignored; it is not queued.
- Write during a scan:
  - The element presented reflects register contents in that cycle.
  - A write to the currently presented, stalled index changes the mux data on the next cycle; the consumer sees the newer value on acceptance.
  - A write to an already-accepted index is not re-dumped.
- clr during a scan clears the registers but does not abort the scan. Remaining elements read RESET_VAL.
- SCAN_LAST = 0: a single-element dump; dump_last is high on the first element.
- Async reset mid-scan aborts immediately to IDLE with all outputs at reset values. No dump_done is produced.
- Throughput: one element per cycle with ready held high. A full dump takes SCAN_LAST + 1 SCAN cycles plus one DONE cycle.

Test Plan:
- Reset then write 8'h10 + i to each index i (16 cycles), then set rd_sel = 5 -> r5 = 8'h15, sel = 4'd5; all r* = 8'h00 before the writes.
- Load as above, pulse dump_start, hold ready = 1 -> sel steps 0..15 on 16 consecutive cycles; dump_last only at sel = 15; dump_done pulses exactly once on the 17th SCAN/DONE cycle; then back in IDLE with sel = rd_sel.
- During a dump, drop ready at sel = 7 for 3 cycles -> sel stays 7 and dump_valid stays 1; scan resumes at 8; total dump length = 19 cycles.
- During a stall at sel = 3, write 8'hAA to index 3 -> r3 = 8'hAA next cycle while sel is still 3. In the same dump, a write to index 1 after it was accepted causes no re-visit of index 1.
- Assert rst_n = 0 mid-scan at sel = 9 -> immediately dump_valid = 0, dump_busy = 0, all r* = RESET_VAL, no dump_done. Separately, clr and wr_en in the same cycle -> register holds RESET_VAL.
- With SCAN_LAST = 3, a dump with ready = 1 -> sel 0, 1, 2, 3 then DONE. dump_start asserted during the SCAN has no effect; a second dump_start in IDLE restarts at sel = 0.
